// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle for mem_access_ctrl.
// The control unit is the master; the sequencer is the slave.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              busy;
  logic              err;
  logic              err_clr;

  modport master (
    output rd_req, wr_req, addr, wr_data, err_clr,
    input  rd_data, done, busy, err
  );

  modport slave (
    input  rd_req, wr_req, addr, wr_data, err_clr,
    output rd_data, done, busy, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences single-word reads/writes into a synchronous BRAM, absorbing its read latency.
// Every output is driven straight from a flop.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StWrIssue, StRdIssue, StRdWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    err_d       = err_q & ~bus.err_clr;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.rd_req && bus.wr_req) begin
          err_d = 1'b1;
        end else if (bus.wr_req) begin
          ram_addr_d  = bus.addr;
          ram_wdata_d = bus.wr_data;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          state_d     = StWrIssue;
        end else if (bus.rd_req) begin
          ram_addr_d = bus.addr;
          ram_en_d   = 1'b1;
          state_d    = StRdIssue;
        end
      end
      StWrIssue: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StRdIssue: begin
        cnt_d   = CntW'(RD_LAT - 1);
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cnt_q == '0) begin
          rd_data_d = ram_rdata_i;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A request while busy is dropped; the in-flight access is untouched.
    if ((state_q != StIdle) && (bus.rd_req || bus.wr_req)) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural two-stage BRAM (RD_LAT = 2).
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [DATA_W-1:0] ram_pipe  = '0;
  logic [DATA_W-1:0] mem [256];

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  // BRAM: samples at the enable edge, data appears one edge later.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_pipe <= mem[ram_addr];
    ram_rdata <= ram_pipe;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 16'h1234;
    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.err_clr = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;

    // Asynchronous reset mid-cycle
    #2 rst = 1'b0;
    #1;
    check_eq("rst_rd_data", 32'(bus.rd_data), 32'h0);
    check_eq("rst_done",    32'(bus.done),    32'h0);
    check_eq("rst_busy",    32'(bus.busy),    32'h0);
    check_eq("rst_err",     32'(bus.err),     32'h0);
    check_eq("rst_ram_en",  32'(ram_en),      32'h0);
    check_eq("rst_ram_we",  32'(ram_we),      32'h0);
    check_eq("rst_addr",    32'(ram_addr),    32'h0);
    check_eq("rst_wdata",   32'(ram_wdata),   32'h0);
    step();
    rst = 1'b1;
    step();
    step();
    check_eq("post_rst_busy", 32'(bus.busy), 32'h0);
    check_eq("post_rst_err",  32'(bus.err),  32'h0);

    // Write 0xBEEF to 0x10
    bus.wr_req = 1'b1; bus.addr = 8'h10; bus.wr_data = 16'hBEEF;
    step();
    bus.wr_req = 1'b0; bus.wr_data = 16'h0000;
    check_eq("wr_en",    32'(ram_en),    32'h1);
    check_eq("wr_we",    32'(ram_we),    32'h1);
    check_eq("wr_addr",  32'(ram_addr),  32'h10);
    check_eq("wr_wdata", 32'(ram_wdata), 32'hBEEF);
    check_eq("wr_busy",  32'(bus.busy),  32'h1);
    check_eq("wr_done0", 32'(bus.done),  32'h0);
    step();
    check_eq("wr_done",  32'(bus.done),  32'h1);
    check_eq("wr_en_off", 32'(ram_en),   32'h0);
    check_eq("wr_busy_off", 32'(bus.busy), 32'h0);
    check_eq("wr_rd_data_hold", 32'(bus.rd_data), 32'h0);
    step();
    check_eq("wr_done_pulse", 32'(bus.done), 32'h0);
    check_eq("wr_wdata_hold", 32'(ram_wdata), 32'hBEEF);

    // Read 0x10, expect 0xBEEF after E3
    bus.rd_req = 1'b1; bus.addr = 8'h10;
    step();
    bus.rd_req = 1'b0;
    check_eq("rd_en",    32'(ram_en),   32'h1);
    check_eq("rd_we",    32'(ram_we),   32'h0);
    check_eq("rd_busy1", 32'(bus.busy), 32'h1);
    step();
    check_eq("rd_en_off", 32'(ram_en),  32'h0);
    check_eq("rd_busy2", 32'(bus.busy), 32'h1);
    check_eq("rd_done_e1", 32'(bus.done), 32'h0);
    step();
    check_eq("rd_busy3", 32'(bus.busy), 32'h1);
    check_eq("rd_done_e2", 32'(bus.done), 32'h0);
    step();
    check_eq("rd_done",  32'(bus.done),    32'h1);
    check_eq("rd_data",  32'(bus.rd_data), 32'hBEEF);
    check_eq("rd_busy_off", 32'(bus.busy), 32'h0);

    // Back-to-back: write 0xCAFE to 0x30, read it in the write's done cycle
    step();
    bus.wr_req = 1'b1; bus.addr = 8'h30; bus.wr_data = 16'hCAFE;
    step();
    bus.wr_req = 1'b0;
    step();
    check_eq("b2b_wr_done", 32'(bus.done), 32'h1);
    bus.rd_req = 1'b1; bus.addr = 8'h30;
    step();
    bus.rd_req = 1'b0;
    check_eq("b2b_rd_en",   32'(ram_en),   32'h1);
    check_eq("b2b_rd_we",   32'(ram_we),   32'h0);
    check_eq("b2b_addr",    32'(ram_addr), 32'h30);
    check_eq("b2b_err",     32'(bus.err),  32'h0);
    step(); step(); step();
    check_eq("b2b_done",    32'(bus.done),    32'h1);
    check_eq("b2b_rd_data", 32'(bus.rd_data), 32'hCAFE);
    check_eq("b2b_err_end", 32'(bus.err),     32'h0);

    // Error: simultaneous requests in idle
    step();
    bus.rd_req = 1'b1; bus.wr_req = 1'b1; bus.addr = 8'h20;
    step();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    check_eq("both_err",  32'(bus.err),     32'h1);
    check_eq("both_en",   32'(ram_en),      32'h0);
    check_eq("both_busy", 32'(bus.busy),    32'h0);
    check_eq("both_data", 32'(bus.rd_data), 32'hCAFE);
    step();
    check_eq("both_en2",  32'(ram_en),      32'h0);

    // Error clear
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check_eq("clr_err", 32'(bus.err), 32'h0);

    // Error: request during RD_WAIT, original read still completes
    bus.rd_req = 1'b1; bus.addr = 8'h20;
    step();
    bus.rd_req = 1'b0;
    step();
    bus.rd_req = 1'b1; bus.addr = 8'h55;
    step();
    bus.rd_req = 1'b0;
    check_eq("busy_err",     32'(bus.err),  32'h1);
    check_eq("busy_err_bsy", 32'(bus.busy), 32'h1);
    check_eq("busy_err_en",  32'(ram_en),   32'h0);
    step();
    check_eq("busy_rd_done", 32'(bus.done),    32'h1);
    check_eq("busy_rd_data", 32'(bus.rd_data), 32'h1234);
    check_eq("busy_rd_addr", 32'(ram_addr),    32'h20);
    check_eq("busy_err_sticky", 32'(bus.err),  32'h1);

    // err_clr together with a new error: set wins
    step();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b1; bus.rd_req = 1'b1; bus.wr_req = 1'b1;
    step();
    bus.err_clr = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    check_eq("clr_vs_set", 32'(bus.err), 32'h1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check_eq("clr_again", 32'(bus.err), 32'h0);

    // Reset during RD_WAIT discards the read
    bus.rd_req = 1'b1; bus.addr = 8'h10;
    step();
    bus.rd_req = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_data", 32'(bus.rd_data), 32'h0);
    check_eq("mid_rst_busy", 32'(bus.busy),    32'h0);
    check_eq("mid_rst_done", 32'(bus.done),    32'h0);
    check_eq("mid_rst_addr", 32'(ram_addr),    32'h0);
    step();
    check_eq("mid_rst_nodone", 32'(bus.done), 32'h0);
    rst = 1'b1;
    step();
    check_eq("mid_rst_nodone2", 32'(bus.done),    32'h0);
    check_eq("mid_rst_data2",   32'(bus.rd_data), 32'h0);

    // Fresh read after reset
    bus.rd_req = 1'b1; bus.addr = 8'h30;
    step();
    bus.rd_req = 1'b0;
    check_eq("re_rd_en", 32'(ram_en), 32'h1);
    step(); step(); step();
    check_eq("re_rd_done", 32'(bus.done),    32'h1);
    check_eq("re_rd_data", 32'(bus.rd_data), 32'hCAFE);
    check_eq("re_rd_err",  32'(bus.err),     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
